t_ff: RTL and testbench
=======================

// Module: t_ff
//
// PURPOSE
//   Positive-edge-triggered toggle (T) flip-flop with complementary outputs.
//   When T is high at a rising clock edge, Q inverts; when T is low, Q holds.
//   Used as a basic sequential building block for counters and frequency
//   dividers. WIDTH > 1 gives a bank of independent T flip-flops.
//
// PARAMETERS
//   WIDTH      1     number of independent toggle bits
//   RESET_VAL  0     value loaded into q on reset (WIDTH bits); qbar = ~RESET_VAL
//
// PORTS
//   clk   input   1       rising-edge clock
//   rst   input   1       asynchronous reset, active-low (0 = reset asserted)
//   t     input   WIDTH   toggle enable, one bit per flip-flop
//   q     output  WIDTH   registered state
//   qbar  output  WIDTH   bitwise complement of q
//   Positional port order (existing instantiations): t, q, qbar, clk, rst
//
// BEHAVIOUR
//   - One clock domain. The design has a single state register, q.
//   - Reset: when rst = 0, q = RESET_VAL immediately, regardless of clk.
//     - With the default parameters, q = 0 and qbar = 1.
//     - While rst stays low, clock edges are ignored.
//   - Reset release: on rst 0->1, q holds RESET_VAL.
//     - The first possible toggle is the first rising clk edge after release.
//     - If the release coincides with a clk edge, that edge has no effect.
//   - Normal operation, at each rising clk edge with rst = 1:
//     q <= q ^ t  (bitwise; each bit toggles only if its t bit is 1).
//   - qbar is combinational: qbar = ~q at all times, including during reset.
//     q and qbar are never equal.
//   - Latency: q reflects t sampled at the edge, one cycle later.
//     t has no combinational path to q or qbar.
//   - t held at 1 continuously: q toggles every cycle, giving a clk/2 square wave.
//   - t held at 0: q holds its value indefinitely.
//   - X/Z on t at an edge: q becomes X for the affected bits.
//     Reset (rst = 0) clears the X.
//   - No other state, no FSM, no handshake.
//
// TESTING
//   1. Async reset: rst=0 in mid-cycle, no clk edge -> q=0, qbar=1 immediately.
//      Also hold rst=0 over 3 edges with t=1 -> q stays 0.
//   2. Hold: rst=1, q=0, t=0 for 4 rising edges -> q=0, qbar=1 throughout.
//   3. Toggle: rst=1, q=0, t=1 for 4 rising edges -> q = 1,0,1,0 after
//      successive edges; qbar is always the complement.
//   4. Mixed t: 10 ns clock (first rising edge at 5 ns); rst=0 until 10 ns.
//      t=0 at 5 ns, 1 at 15 ns, 0 at 30 ns, 1 at 50 ns, 0 at 75 ns,
//      1 at 105 ns, 0 at 140 ns.
//      -> q=0 until 25 ns; 1 at 25 ns; 0 at 55 ns; 1 at 65 ns; holds 1
//         until 115 ns; then toggles at 115, 125 and 135 ns.
//      (At the 15 ns edge, q goes to 1 only if t=1 was sampled there;
//       the bench must not drive t at the same instant as a clock edge.)
//   5. Reset mid-operation: toggling with t=1, assert rst=0 while q=1
//      -> q=0, qbar=1 at once. Release with t=1 -> first toggle to q=1
//      occurs at the first edge after release.
//   6. WIDTH=4 variant: q=4'b0000, t=4'b1010 for 2 edges
//      -> q=4'b1010, then 4'b0000; qbar = ~q.

Source files
------------

// File: rtl/t_ff.sv
`default_nettype none
// ============================================================================
//  Module   : t_ff
//  Purpose  : Bank of WIDTH independent toggle flip-flops with complementary
//             outputs; asynchronous active-low reset loads RESET_VAL.
//  Revision : 1.0
// ============================================================================
module t_ff #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH-1:0] w_state_d;
    logic [WIDTH-1:0] r_state_q;

    always_comb begin
        w_state_d = r_state_q ^ t;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= RESET_VAL;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // qbar tracks q combinationally so it is valid during reset as well
    assign q    = r_state_q;
    assign qbar = ~r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_t_ff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_ff
//  Purpose  : Self-checking bench for t_ff (WIDTH=1 default and WIDTH=4).
//  Revision : 1.0
// ============================================================================
module tb_t_ff;

    localparam logic [3:0] c_rst_val4 = 4'b0110;

    logic       clk;
    logic       rst;
    logic       t1;
    logic       q1;
    logic       qbar1;
    logic [3:0] t4;
    logic [3:0] q4;
    logic [3:0] qbar4;

    int n_tests;
    int n_fail;

    // t sampled at each rising edge (5 ns + 10k) and q right after it
    bit ts  [15] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
    bit eq  [15] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0};

    t_ff u_dut1 (
        .t    (t1),
        .q    (q1),
        .qbar (qbar1),
        .clk  (clk),
        .rst  (rst)
    );

    t_ff #(.WIDTH(4), .RESET_VAL(c_rst_val4)) u_dut4 (
        .t    (t4),
        .q    (q4),
        .qbar (qbar4),
        .clk  (clk),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: each bit counts its toggle requests modulo 2
    function automatic logic [3:0] toggle_model(input logic [3:0] cur, input logic [3:0] tg);
        logic [3:0] nxt;
        for (int i = 0; i < 4; i++) nxt[i] = 1'((int'(cur[i]) + int'(tg[i])) % 2);
        return nxt;
    endfunction

    task automatic edge_check1(input string tag, input logic exp);
        @(posedge clk);
        #1;
        check_eq(tag, {3'b0, q1}, {3'b0, exp});
        check_eq({tag, "_qbar"}, {3'b0, qbar1}, {3'b0, ~exp});
    endtask

    initial begin
        logic       m1;
        logic [3:0] m4;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        t1  = 1'b0;
        t4  = 4'b0;

        // Mixed-t timeline, reset released at 10 ns, t changed at falling edges
        for (int k = 0; k < 15; k++) begin
            if (k == 0) begin
                t1 = ts[0];
            end else begin
                @(negedge clk);
                if (k == 1) rst = 1'b1;
                t1 = ts[k];
            end
            edge_check1("mixed", eq[k]);
        end
        check_eq("w4_hold_rstval", q4, c_rst_val4);

        // Hold with t=0
        @(negedge clk); t1 = 1'b0;
        for (int k = 0; k < 4; k++) edge_check1("hold", 1'b0);

        // Toggle with t=1: 1,0,1,0
        @(negedge clk); t1 = 1'b1;
        for (int k = 0; k < 4; k++) edge_check1("toggle", 1'(k % 2 == 0));

        // Async reset mid-cycle while q=1, no clock edge involved
        edge_check1("pre_reset", 1'b1);
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst_q", {3'b0, q1}, 4'b0);
        check_eq("async_rst_qbar", {3'b0, qbar1}, 4'b1);
        check_eq("async_rst_q4", q4, c_rst_val4);
        check_eq("async_rst_qbar4", qbar4, ~c_rst_val4);
        for (int k = 0; k < 3; k++) edge_check1("rst_held", 1'b0);

        // Release with t=1: first toggle at the first edge after release
        @(negedge clk); rst = 1'b1;
        #1 check_eq("release_no_toggle", {3'b0, q1}, 4'b0);
        edge_check1("first_toggle", 1'b1);

        // WIDTH=4: bring to 0000, then t=1010 for two edges
        @(negedge clk); t4 = c_rst_val4;
        @(posedge clk); #1 check_eq("w4_clear", q4, 4'b0000);
        @(negedge clk); t4 = 4'b1010;
        @(posedge clk); #1 check_eq("w4_first", q4, 4'b1010);
        check_eq("w4_first_qbar", qbar4, 4'b0101);
        @(posedge clk); #1 check_eq("w4_second", q4, 4'b0000);
        check_eq("w4_second_qbar", qbar4, 4'b1111);

        // Randomised phase, models start from a reset
        @(negedge clk); rst = 1'b0;
        m1 = 1'b0;
        m4 = c_rst_val4;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 15) != 0);
            t1  = 1'($urandom);
            t4  = 4'($urandom);
            #1;
            if (!rst) begin
                m1 = 1'b0;
                m4 = c_rst_val4;
            end
            check_eq("rnd_async_q1", {3'b0, q1}, {3'b0, m1});
            @(posedge clk);
            #1;
            if (rst) begin
                m1 = toggle_model({3'b0, m1}, {3'b0, t1})[0];
                m4 = toggle_model(m4, t4);
            end
            check_eq("rnd_q1", {3'b0, q1}, {3'b0, m1});
            check_eq("rnd_qbar1", {3'b0, qbar1}, {3'b0, ~m1});
            check_eq("rnd_q4", q4, m4);
            check_eq("rnd_qbar4", qbar4, ~m4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
